flags_reg_stage: RTL and testbench
==================================

FLAGS_REG_STAGE -- requirements
Module: flags_reg_stage

Interface
REQ-001 SHALL have parameter ALU_FLAGS_WIDTH, default 5, flag vector width ordered {S,N,Z,C,V} (S = sticky saturation).
REQ-002 SHALL have ports:
  clk  in  1  sole clock, rising edge
  reset  in  1  asynchronous, active-high
  valid_e  in  1  execute-stage instruction valid
  stall_e  in  1  execute stage held this cycle
  flush_e  in  1  execute instruction squashed this cycle
  cond_ex  in  1  condition-pass result for execute instruction
  flags_write  in  2  [1]=update N,Z; [0]=update C,V
  alu_flags  in  5  flags produced by ALU, {S,N,Z,C,V}
  sat_set  in  1  execute instruction saturated
  sat_clr  in  1  execute instruction explicitly clears S
  dec_cond  in  4  decode-stage condition code
  dec_flags_write  in  2  decode-stage flag-write mask
  mc_start  in  1  multi-cycle flag-setting op launched from execute
  mc_fw  in  2  flag-write mask of that op (same encoding as flags_write)
  mc_done  in  1  multi-cycle op result ready
  mc_flags  in  5  flags from multi-cycle op
  flags  out  5  architectural flag register, feeds condition evaluation
  mc_busy  out  1  multi-cycle op pending
  flag_stall  out  1  hold decode: it needs flags not yet produced
  mc_overrun  out  1  one-cycle pulse: mc_start ignored while busy

Function
REQ-003 Commit SHALL mean valid_e & ~stall_e & ~flush_e & cond_ex at a rising edge.
REQ-004 On commit, flags[3:2] SHALL load alu_flags[3:2] if flags_write[1], flags[1:0] SHALL load alu_flags[1:0] if flags_write[0]; unselected bits hold.
REQ-005 S SHALL be sticky: set on commit with sat_set, cleared only on commit with sat_clr; both asserted -> set wins.
REQ-006 Flag updates SHALL become visible on flags exactly one cycle after the committing edge; no combinational bypass.
REQ-007 FSM states IDLE, BUSY; IDLE->BUSY on mc_start & valid_e & ~stall_e & ~flush_e & cond_ex, capturing mc_fw into a pending mask; mc_start with mc_fw==0 SHALL NOT leave IDLE.
REQ-008 In BUSY, mc_done SHALL load mc_flags[3:2]/[1:0] per pending mask bits [1]/[0] and return to IDLE; mc_flags[4] ignored.
REQ-009 mc_done in IDLE SHALL be ignored.
REQ-010 mc_done and a qualifying mc_start in the same BUSY cycle SHALL complete the old op and capture the new mask, remaining BUSY.
REQ-011 Qualifying mc_start in BUSY without mc_done SHALL be ignored and pulse mc_overrun for one cycle.
REQ-012 mc_busy SHALL equal (state==BUSY).
REQ-013 flag_stall SHALL be combinational: mc_busy & ~mc_done & ((dec_cond != 4'b1110) | (dec_flags_write != 0)).
REQ-014 If execute commit and mc_done write the same bit in one cycle, the execute commit value SHALL win (younger instruction).
REQ-015 flush_e SHALL suppress only the execute commit; a pending multi-cycle op SHALL NOT be cancelled.
REQ-016 stall_e SHALL freeze commit and launch but SHALL NOT block mc_done completion.

Reset
REQ-017 reset SHALL asynchronously force flags=5'b0, state=IDLE, pending mask=0, mc_overrun=0; mc_busy=0 follows.
REQ-018 Reset asserted mid multi-cycle op SHALL discard it; a later mc_done SHALL be ignored.

Structure
REQ-019 ALU_FLAGS_WIDTH, flag bit indices (S=4,N=3,Z=2,C=1,V=0), AL encoding 4'b1110 and FSM state type SHALL live in the shared pipeline package.
REQ-020 The IDLE/BUSY tracker SHALL be one sub-module, flags_pending_fsm; flag register and merge logic stay in the top.

Verification
REQ-021 Bench SHALL cover:
  reset, commit flags_write=2'b11 alu_flags=5'b01010 -> next cycle flags=5'b01010.
  flags=5'b01111, commit flags_write=2'b10 alu_flags=5'b00000 -> flags=5'b00011; same with cond_ex=0 or flush_e=1 -> unchanged.
  commit sat_set -> S=1; five commits without sat_clr -> S stays 1; sat_set&sat_clr -> S=1; sat_clr alone -> S=0.
  mc_start mc_fw=2'b01, decode dec_cond=4'b0000 -> flag_stall=1 until mc_done mc_flags=5'b00011 -> flags[1:0]=2'b11, mc_busy=0 next cycle.
  second mc_start while BUSY -> mc_overrun single pulse, mask unchanged; mc_done+mc_start same cycle -> mc_busy stays 1.
  reset during BUSY, then mc_done -> flags stay 5'b0, mc_busy=0.

Source files
------------

// File: rtl/flags_reg_stage_pkg.sv
// Shared pipeline definitions for the flag register stage: widths, flag bit
// positions, the always-true condition code and the pending-op state type.
package flags_reg_stage_pkg;

    localparam int unsigned ALU_FLAGS_WIDTH = 5;
    localparam int unsigned FW_WIDTH        = 2;
    localparam int unsigned COND_WIDTH      = 4;

    localparam int unsigned FLAG_S = 4;
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam logic [COND_WIDTH-1:0] COND_AL = 4'b1110;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } pend_state_e;

endpackage

// File: rtl/flags_pending_fsm.sv
// Tracks one outstanding multi-cycle flag-setting op: its write mask,
// completion, and rejected launches while it is still in flight.
module flags_pending_fsm
    import flags_reg_stage_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                launch_i,
    input  logic [FW_WIDTH-1:0] mc_fw_i,
    input  logic                mc_done_i,
    output logic                mc_busy_o,
    output logic [FW_WIDTH-1:0] pend_mask_o,
    output logic                mc_overrun_o,
    output logic                mc_complete_c_o
);

    pend_state_e         state_q, state_d;
    logic [FW_WIDTH-1:0] mask_q, mask_d;
    logic                overrun_q, overrun_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mask_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            overrun_q <= overrun_d;
        end
    end

    // A launch with an empty mask has nothing to wait for, so it never leaves IDLE.
    always_comb begin
        state_d         = state_q;
        mask_d          = mask_q;
        overrun_d       = 1'b0;
        mc_complete_c_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (launch_i && (mc_fw_i != '0)) begin
                    state_d = ST_BUSY;
                    mask_d  = mc_fw_i;
                end
            end
            ST_BUSY: begin
                if (mc_done_i) begin
                    mc_complete_c_o = 1'b1;
                    if (launch_i && (mc_fw_i != '0)) begin
                        mask_d = mc_fw_i;
                    end else begin
                        state_d = ST_IDLE;
                        mask_d  = '0;
                    end
                end else if (launch_i) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                mask_d  = '0;
            end
        endcase
    end

    assign mc_busy_o    = (state_q == ST_BUSY);
    assign pend_mask_o  = mask_q;
    assign mc_overrun_o = overrun_q;

endmodule

// File: rtl/flags_reg_stage.sv
// Architectural {S,N,Z,C,V} flag register: merges execute-stage commits and
// multi-cycle op results, and stalls decode while flags are still pending.
module flags_reg_stage
    import flags_reg_stage_pkg::*;
#(
    parameter int unsigned ALU_FLAGS_WIDTH = flags_reg_stage_pkg::ALU_FLAGS_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid_e,
    input  logic                       stall_e,
    input  logic                       flush_e,
    input  logic                       cond_ex,
    input  logic [FW_WIDTH-1:0]        flags_write,
    input  logic [ALU_FLAGS_WIDTH-1:0] alu_flags,
    input  logic                       sat_set,
    input  logic                       sat_clr,
    input  logic [COND_WIDTH-1:0]      dec_cond,
    input  logic [FW_WIDTH-1:0]        dec_flags_write,
    input  logic                       mc_start,
    input  logic [FW_WIDTH-1:0]        mc_fw,
    input  logic                       mc_done,
    input  logic [ALU_FLAGS_WIDTH-1:0] mc_flags,
    output logic [ALU_FLAGS_WIDTH-1:0] flags,
    output logic                       mc_busy,
    output logic                       flag_stall,
    output logic                       mc_overrun
);

    logic [ALU_FLAGS_WIDTH-1:0] flags_q, flags_d;
    logic [FW_WIDTH-1:0]        pend_mask;
    logic                       commit_c;
    logic                       mc_complete_c;
    logic                       unused_s_bits;

    assign commit_c = valid_e & ~stall_e & ~flush_e & cond_ex;

    // S only moves through sat_set/sat_clr; the S bits of both flag buses are don't-care.
    assign unused_s_bits = alu_flags[FLAG_S] ^ mc_flags[FLAG_S];

    flags_pending_fsm u_pending (
        .clk             (clk),
        .reset           (reset),
        .launch_i        (mc_start & commit_c),
        .mc_fw_i         (mc_fw),
        .mc_done_i       (mc_done),
        .mc_busy_o       (mc_busy),
        .pend_mask_o     (pend_mask),
        .mc_overrun_o    (mc_overrun),
        .mc_complete_c_o (mc_complete_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    // Older multi-cycle result first, so the younger execute commit overrides it.
    always_comb begin
        flags_d = flags_q;
        if (mc_complete_c) begin
            if (pend_mask[1]) begin
                flags_d[FLAG_N] = mc_flags[FLAG_N];
                flags_d[FLAG_Z] = mc_flags[FLAG_Z];
            end
            if (pend_mask[0]) begin
                flags_d[FLAG_C] = mc_flags[FLAG_C];
                flags_d[FLAG_V] = mc_flags[FLAG_V];
            end
        end
        if (commit_c) begin
            if (flags_write[1]) begin
                flags_d[FLAG_N] = alu_flags[FLAG_N];
                flags_d[FLAG_Z] = alu_flags[FLAG_Z];
            end
            if (flags_write[0]) begin
                flags_d[FLAG_C] = alu_flags[FLAG_C];
                flags_d[FLAG_V] = alu_flags[FLAG_V];
            end
            if (sat_set) begin
                flags_d[FLAG_S] = 1'b1;
            end else if (sat_clr) begin
                flags_d[FLAG_S] = 1'b0;
            end
        end
    end

    assign flags      = flags_q;
    assign flag_stall = mc_busy & ~mc_done
                      & ((dec_cond != COND_AL) | (dec_flags_write != '0));

endmodule

// File: tb/tb_flags_reg_stage.sv
// Self-checking bench for flags_reg_stage: directed scenarios plus a random
// run compared against a rule-level reference model.
module tb_flags_reg_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_e, stall_e, flush_e, cond_ex;
    logic [1:0] flags_write;
    logic [4:0] alu_flags;
    logic       sat_set, sat_clr;
    logic [3:0] dec_cond;
    logic [1:0] dec_flags_write;
    logic       mc_start;
    logic [1:0] mc_fw;
    logic       mc_done;
    logic [4:0] mc_flags;
    logic [4:0] flags;
    logic       mc_busy, flag_stall, mc_overrun;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [4:0] m_flags;
    logic       m_busy;
    logic [1:0] m_mask;
    logic       m_ovr;

    flags_reg_stage #(.ALU_FLAGS_WIDTH(5)) dut (
        .clk(clk), .reset(reset), .valid_e(valid_e), .stall_e(stall_e),
        .flush_e(flush_e), .cond_ex(cond_ex), .flags_write(flags_write),
        .alu_flags(alu_flags), .sat_set(sat_set), .sat_clr(sat_clr),
        .dec_cond(dec_cond), .dec_flags_write(dec_flags_write),
        .mc_start(mc_start), .mc_fw(mc_fw), .mc_done(mc_done),
        .mc_flags(mc_flags), .flags(flags), .mc_busy(mc_busy),
        .flag_stall(flag_stall), .mc_overrun(mc_overrun)
    );

    always #5 clk = ~clk;

    function automatic logic model_stall();
        return m_busy && !mc_done && (dec_cond != 4'd14 || dec_flags_write != 2'd0);
    endfunction

    task automatic model_reset();
        m_flags = 5'd0; m_busy = 1'b0; m_mask = 2'd0; m_ovr = 1'b0;
    endtask

    // Apply the architectural rules for one rising edge
    task automatic model_edge();
        logic       commit;
        logic [4:0] nf;
        commit = valid_e && !stall_e && !flush_e && cond_ex;
        nf = m_flags;
        if (m_busy && mc_done) begin
            if (m_mask[1]) nf[3:2] = mc_flags[3:2];
            if (m_mask[0]) nf[1:0] = mc_flags[1:0];
        end
        if (commit) begin
            if (flags_write[1]) nf[3:2] = alu_flags[3:2];
            if (flags_write[0]) nf[1:0] = alu_flags[1:0];
            if (sat_set) nf[4] = 1'b1;
            else if (sat_clr) nf[4] = 1'b0;
        end
        m_ovr = m_busy && !mc_done && commit && mc_start;
        if (!(m_busy && !mc_done)) begin
            if (commit && mc_start && mc_fw != 2'd0) begin
                m_busy = 1'b1; m_mask = mc_fw;
            end else begin
                m_busy = 1'b0; m_mask = 2'd0;
            end
        end
        m_flags = nf;
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset) model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        valid_e = 0; stall_e = 0; flush_e = 0; cond_ex = 0;
        flags_write = 0; alu_flags = 0; sat_set = 0; sat_clr = 0;
        dec_cond = 4'b1110; dec_flags_write = 0;
        mc_start = 0; mc_fw = 0; mc_done = 0; mc_flags = 0;
    endtask

    task automatic drive_commit(input logic [1:0] fw, input logic [4:0] alu,
                                input logic ss, input logic sc);
        valid_e = 1; stall_e = 0; flush_e = 0; cond_ex = 1;
        flags_write = fw; alu_flags = alu; sat_set = ss; sat_clr = sc;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        model_reset();
        total++; if (flags !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b exp=%b", flags, 5'b0); end
        total++; if (mc_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", mc_busy); end
        total++; if (mc_overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b exp=0", mc_overrun); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_commit();
        drive_commit(2'b11, 5'b01010, 0, 0);
        #1;
        total++; if (flags !== 5'b00000) begin bad++; $display("FAIL no_bypass got=%b exp=%b", flags, 5'b0); end
        step(); idle_inputs();
        total++; if (flags !== 5'b01010) begin bad++; $display("FAIL commit_all got=%b exp=%b", flags, 5'b01010); end
    endtask

    task automatic test_partial();
        drive_commit(2'b11, 5'b01111, 0, 0); step();
        drive_commit(2'b10, 5'b00000, 0, 0); step(); idle_inputs();
        total++; if (flags !== 5'b00011) begin bad++; $display("FAIL partial_nz got=%b exp=%b", flags, 5'b00011); end
        drive_commit(2'b11, 5'b01100, 1, 0); cond_ex = 0; step();
        total++; if (flags !== 5'b00011) begin bad++; $display("FAIL cond_fail got=%b exp=%b", flags, 5'b00011); end
        drive_commit(2'b11, 5'b01100, 1, 0); flush_e = 1; step();
        total++; if (flags !== 5'b00011) begin bad++; $display("FAIL flush got=%b exp=%b", flags, 5'b00011); end
        drive_commit(2'b11, 5'b01100, 1, 0); stall_e = 1; step(); idle_inputs();
        total++; if (flags !== 5'b00011) begin bad++; $display("FAIL stall got=%b exp=%b", flags, 5'b00011); end
    endtask

    task automatic test_sticky();
        drive_commit(2'b00, 5'b00000, 1, 0); step();
        total++; if (flags[4] !== 1'b1) begin bad++; $display("FAIL sat_set got=%b exp=1", flags[4]); end
        for (int i = 0; i < 5; i++) begin
            drive_commit(2'b11, 5'b00000, 0, 0); step();
            total++; if (flags[4] !== 1'b1) begin bad++; $display("FAIL sat_hold%0d got=%b exp=1", i, flags[4]); end
        end
        drive_commit(2'b00, 5'b00000, 1, 1); step();
        total++; if (flags[4] !== 1'b1) begin bad++; $display("FAIL sat_both got=%b exp=1", flags[4]); end
        drive_commit(2'b00, 5'b00000, 0, 1); step(); idle_inputs();
        total++; if (flags[4] !== 1'b0) begin bad++; $display("FAIL sat_clr got=%b exp=0", flags[4]); end
    endtask

    task automatic test_mc();
        drive_commit(2'b11, 5'b01100, 0, 0); step();
        drive_commit(2'b00, 5'b00000, 0, 0); mc_start = 1; mc_fw = 2'b00; step();
        total++; if (mc_busy !== 1'b0) begin bad++; $display("FAIL mc_fw0 got=%b exp=0", mc_busy); end
        drive_commit(2'b00, 5'b00000, 0, 0); mc_start = 1; mc_fw = 2'b01; step(); idle_inputs();
        total++; if (mc_busy !== 1'b1) begin bad++; $display("FAIL mc_busy got=%b exp=1", mc_busy); end
        dec_cond = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (flag_stall !== 1'b1) begin bad++; $display("FAIL stall_wait%0d got=%b exp=1", i, flag_stall); end
            step();
        end
        dec_cond = 4'b1110; #1;
        total++; if (flag_stall !== 1'b0) begin bad++; $display("FAIL stall_al got=%b exp=0", flag_stall); end
        dec_flags_write = 2'b01; #1;
        total++; if (flag_stall !== 1'b1) begin bad++; $display("FAIL stall_al_fw got=%b exp=1", flag_stall); end
        dec_flags_write = 2'b00; dec_cond = 4'b0000;
        mc_done = 1; mc_flags = 5'b00011; #1;
        total++; if (flag_stall !== 1'b0) begin bad++; $display("FAIL stall_done got=%b exp=0", flag_stall); end
        step(); idle_inputs();
        total++; if (flags !== 5'b01111) begin bad++; $display("FAIL mc_result got=%b exp=%b", flags, 5'b01111); end
        total++; if (mc_busy !== 1'b0) begin bad++; $display("FAIL mc_idle got=%b exp=0", mc_busy); end
    endtask

    task automatic test_overrun();
        drive_commit(2'b11, 5'b00011, 0, 0); step();
        drive_commit(2'b00, 5'b00000, 0, 0); mc_start = 1; mc_fw = 2'b10; step();
        drive_commit(2'b00, 5'b00000, 0, 0); mc_start = 1; mc_fw = 2'b01; step(); idle_inputs();
        total++; if (mc_overrun !== 1'b1) begin bad++; $display("FAIL ovr_pulse got=%b exp=1", mc_overrun); end
        step();
        total++; if (mc_overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", mc_overrun); end
        total++; if (mc_busy !== 1'b1) begin bad++; $display("FAIL ovr_busy got=%b exp=1", mc_busy); end
        drive_commit(2'b00, 5'b00000, 0, 0); mc_start = 1; mc_fw = 2'b01;
        mc_done = 1; mc_flags = 5'b01100; step(); idle_inputs();
        total++; if (flags !== 5'b01111) begin bad++; $display("FAIL ovr_mask got=%b exp=%b", flags, 5'b01111); end
        total++; if (mc_busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b exp=1", mc_busy); end
        total++; if (mc_overrun !== 1'b0) begin bad++; $display("FAIL b2b_ovr got=%b exp=0", mc_overrun); end
        mc_done = 1; mc_flags = 5'b00000; step(); idle_inputs();
        total++; if (flags !== 5'b01100) begin bad++; $display("FAIL b2b_mask got=%b exp=%b", flags, 5'b01100); end
        total++; if (mc_busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", mc_busy); end
    endtask

    task automatic test_collision();
        drive_commit(2'b00, 5'b00000, 0, 0); mc_start = 1; mc_fw = 2'b11; step();
        drive_commit(2'b11, 5'b00000, 0, 0); mc_done = 1; mc_flags = 5'b11111; step(); idle_inputs();
        total++; if (flags !== 5'b00000) begin bad++; $display("FAIL exec_wins got=%b exp=%b", flags, 5'b0); end
        drive_commit(2'b00, 5'b00000, 0, 0); mc_start = 1; mc_fw = 2'b11; step();
        drive_commit(2'b11, 5'b01010, 0, 0); stall_e = 1; mc_done = 1; mc_flags = 5'b00101; step(); idle_inputs();
        total++; if (flags !== 5'b00101) begin bad++; $display("FAIL done_in_stall got=%b exp=%b", flags, 5'b00101); end
        total++; if (mc_busy !== 1'b0) begin bad++; $display("FAIL done_in_stall_busy got=%b exp=0", mc_busy); end
        drive_commit(2'b00, 5'b00000, 0, 0); mc_start = 1; mc_fw = 2'b01; step();
        drive_commit(2'b11, 5'b01111, 0, 0); flush_e = 1; mc_start = 1; mc_fw = 2'b10; step(); idle_inputs();
        total++; if (mc_busy !== 1'b1 || mc_overrun !== 1'b0) begin bad++; $display("FAIL flush_keeps_op got=%b%b exp=10", mc_busy, mc_overrun); end
        mc_done = 1; mc_flags = 5'b00010; step(); idle_inputs();
        total++; if (flags !== 5'b00110) begin bad++; $display("FAIL flush_done got=%b exp=%b", flags, 5'b00110); end
    endtask

    task automatic test_reset_busy();
        drive_commit(2'b00, 5'b00000, 0, 0); mc_start = 1; mc_fw = 2'b11; step(); idle_inputs();
        total++; if (mc_busy !== 1'b1) begin bad++; $display("FAIL rb_busy got=%b exp=1", mc_busy); end
        #2 reset = 1'b1; #1;
        model_reset();
        total++; if (flags !== 5'b0 || mc_busy !== 1'b0) begin bad++; $display("FAIL rb_async got=%b/%b exp=00000/0", flags, mc_busy); end
        @(negedge clk); reset = 1'b0;
        mc_done = 1; mc_flags = 5'b11111; step(); idle_inputs();
        total++; if (flags !== 5'b0) begin bad++; $display("FAIL rb_done_flags got=%b exp=%b", flags, 5'b0); end
        total++; if (mc_busy !== 1'b0) begin bad++; $display("FAIL rb_done_busy got=%b exp=0", mc_busy); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            valid_e = ($urandom_range(3) != 0); stall_e = ($urandom_range(4) == 0);
            flush_e = ($urandom_range(6) == 0); cond_ex = ($urandom_range(4) != 0);
            flags_write = 2'($urandom); alu_flags = 5'($urandom);
            sat_set = ($urandom_range(5) == 0); sat_clr = ($urandom_range(5) == 0);
            dec_cond = ($urandom_range(1) == 0) ? 4'b1110 : 4'($urandom);
            dec_flags_write = 2'($urandom);
            mc_start = ($urandom_range(3) == 0); mc_fw = 2'($urandom);
            mc_done = ($urandom_range(2) == 0); mc_flags = 5'($urandom);
            #1;
            total++; if (flag_stall !== model_stall()) begin bad++; $display("FAIL rnd_stall%0d got=%b exp=%b", i, flag_stall, model_stall()); end
            step();
            total++; if (flags !== m_flags) begin bad++; $display("FAIL rnd_flags%0d got=%b exp=%b", i, flags, m_flags); end
            total++; if (mc_busy !== m_busy) begin bad++; $display("FAIL rnd_busy%0d got=%b exp=%b", i, mc_busy, m_busy); end
            total++; if (mc_overrun !== m_ovr) begin bad++; $display("FAIL rnd_ovr%0d got=%b exp=%b", i, mc_overrun, m_ovr); end
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        test_reset();
        test_commit();
        test_partial();
        test_sticky();
        test_mc();
        test_overrun();
        test_collision();
        test_reset_busy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
